// File: rtl/symbol_framer.sv
// symbol_framer: byte stream to 5-bit symbols for the 3-dimension modulator.
// Frames get a preamble, each symbol is held for SAMPLES_PER_SYMBOL clocks.
module symbol_framer #(
    parameter int DIM0_WIDTH         = 2,
    parameter int DIM1_WIDTH         = 2,
    parameter int DIM2_WIDTH         = 1,
    parameter int SAMPLES_PER_SYMBOL = 10,
    parameter int COUNTER_SIZE       = 4,
    parameter int PREAMBLE_LEN       = 4,
    parameter logic [DIM0_WIDTH+DIM1_WIDTH+DIM2_WIDTH-1:0] PREAMBLE_SYM = 5'b10101,
    parameter logic [DIM0_WIDTH+DIM1_WIDTH+DIM2_WIDTH-1:0] IDLE_SYM     = 5'b00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DIM0_WIDTH-1:0] x0,
    output logic [DIM1_WIDTH-1:0] x1,
    output logic [DIM2_WIDTH-1:0] x2,
    output logic                  sym_start,
    output logic                  busy,
    output logic                  underrun
);

    localparam int SYM_W = DIM0_WIDTH + DIM1_WIDTH + DIM2_WIDTH;
    localparam int BUF_W = SYM_W + 7;
    localparam int BC_W  = $clog2(BUF_W + 1);
    localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [COUNTER_SIZE-1:0] sample_cnt;
    logic                    boundary;
    logic [BUF_W-1:0]        buffer;
    logic [BC_W-1:0]         bit_cnt;
    logic                    last_seen;
    logic [PRE_W-1:0]        pre_cnt;
    logic [PRE_W-1:0]        pre_nx;
    logic [SYM_W-1:0]        sym;
    logic [SYM_W-1:0]        sym_nx;
    logic                    und_nx;
    logic                    data_rule;
    logic                    consume;
    logic                    drain;
    logic                    clear_last;
    logic                    accept;
    logic [BUF_W-1:0]        ins;

    assign boundary = (sample_cnt == COUNTER_SIZE'(SAMPLES_PER_SYMBOL - 1));

    // State register, symbol timing and bit buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            buffer     <= '0;
            last_seen  <= 1'b0;
            pre_cnt    <= '0;
            sym        <= IDLE_SYM;
            sym_start  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sample_cnt <= boundary ? '0 : sample_cnt + COUNTER_SIZE'(1);
            sym_start  <= boundary;
            state      <= state_nx;
            pre_cnt    <= pre_nx;
            sym        <= sym_nx;
            underrun   <= und_nx;
            if (accept) begin
                buffer    <= buffer | ins;
                bit_cnt   <= bit_cnt + BC_W'(8);
                last_seen <= last_seen | in_last;
            end else if (consume) begin
                buffer  <= buffer << SYM_W;
                bit_cnt <= bit_cnt - BC_W'(SYM_W);
            end else if (drain) begin
                buffer  <= '0;
                bit_cnt <= '0;
            end
            if (clear_last) begin
                last_seen <= 1'b0;
            end
        end
    end

    // Next-state and symbol choice, evaluated only at a boundary.
    always_comb begin
        state_nx   = state;
        pre_nx     = pre_cnt;
        sym_nx     = sym;
        und_nx     = underrun;
        data_rule  = 1'b0;
        consume    = 1'b0;
        drain      = 1'b0;
        clear_last = 1'b0;
        if (boundary) begin
            und_nx = 1'b0;
            sym_nx = IDLE_SYM;
            unique case (state)
                S_IDLE: begin
                    if (bit_cnt != '0) begin
                        sym_nx   = PREAMBLE_SYM;
                        pre_nx   = PRE_W'(1);
                        state_nx = S_PRE;
                    end
                end
                S_PRE: begin
                    if (pre_cnt < PRE_W'(PREAMBLE_LEN)) begin
                        sym_nx = PREAMBLE_SYM;
                        pre_nx = pre_cnt + PRE_W'(1);
                    end else begin
                        state_nx  = S_DATA;
                        data_rule = 1'b1;
                    end
                end
                S_DATA: begin
                    data_rule = 1'b1;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
            if (data_rule) begin
                if (bit_cnt >= BC_W'(SYM_W)) begin
                    sym_nx  = buffer[BUF_W-1 -: SYM_W];
                    consume = 1'b1;
                end else if (bit_cnt != '0 && last_seen) begin
                    // Bits below bit_cnt are always zero: LSB padding.
                    sym_nx = buffer[BUF_W-1 -: SYM_W];
                    drain  = 1'b1;
                end else if (last_seen) begin
                    state_nx   = S_IDLE;
                    clear_last = 1'b1;
                end else begin
                    und_nx = 1'b1;
                end
            end
        end
    end

    // Handshake, status and symbol slicing onto the modulator inputs.
    always_comb begin
        in_ready = rst && !last_seen && (bit_cnt < BC_W'(SYM_W));
        accept   = in_valid && in_ready;
        ins      = {in_data, {(BUF_W-8){1'b0}}} >> bit_cnt;
        busy     = (state != S_IDLE) || (bit_cnt != '0);
        x0       = sym[SYM_W-1 -: DIM0_WIDTH];
        x1       = sym[DIM1_WIDTH+DIM2_WIDTH-1 : DIM2_WIDTH];
        x2       = sym[DIM2_WIDTH-1:0];
    end

endmodule
